// File: rtl/tflaf_mse_monitor.sv
// Running mean-square error monitor for the TFLAF filter: EWMA of err^2 plus convergence FSM.
// Build option: define MSE_PEAK_EN to keep a peak-hold register on mse_out.
module tflaf_mse_monitor #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned QP       = 12,
    parameter int unsigned ALPHA_SH = 5,
    parameter int unsigned WARMUP   = 64,
    parameter int unsigned HOLD     = 32,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] err_in,
    input  logic             err_valid,
    input  logic             clear,
    input  logic [WIDTH-1:0] conv_thr,
    input  logic [WIDTH-1:0] div_thr,
    output logic [WIDTH-1:0] mse_out,
    output logic             mse_valid,
    output logic             converged,
    output logic             diverged,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [WIDTH-1:0] mse_peak
);

    localparam int unsigned AccW  = 2 * WIDTH;
    localparam int unsigned HoldW = $clog2(HOLD + 1);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StWarmup = 3'd1;
    localparam logic [2:0] StTrack  = 3'd2;
    localparam logic [2:0] StConv   = 3'd3;
    localparam logic [2:0] StDiv    = 3'd4;

    // Stage 1: square and rescale
    logic signed [AccW-1:0] err_ext;
    logic signed [AccW-1:0] sq;
    logic        [AccW-1:0] sq_s;
    logic                   s1_valid_q;
    logic        [AccW-1:0] s1_sq_q;

    assign err_ext = AccW'($signed(err_in));
    assign sq      = err_ext * err_ext;
    assign sq_s    = $unsigned(sq) >> QP;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_sq_q    <= '0;
        end else begin
            s1_valid_q <= err_valid & ~clear;
            if (err_valid && !clear) begin
                s1_sq_q <= sq_s;
            end
        end
    end

    // Stage 2: EWMA update and status FSM
    logic [AccW-1:0]        acc_q;
    logic [WIDTH-1:0]       mse_q;
    logic                   mse_valid_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [2:0]             state_q, state_d;
    logic [HoldW-1:0]       hold_q, hold_d;

    logic                   upd;
    logic signed [AccW:0]   diff;
    logic signed [AccW:0]   step;
    logic [AccW-1:0]        acc_ewma;
    logic [AccW-1:0]        acc_next;
    logic [WIDTH-1:0]       mse_next;
    logic [CNT_W-1:0]       cnt_next;

    assign upd      = s1_valid_q & ~clear;
    assign diff     = $signed({1'b0, s1_sq_q}) - $signed({1'b0, acc_q});
    assign step     = diff >>> ALPHA_SH;
    // Result is never negative, so truncating the step to AccW bits is exact.
    assign acc_ewma = acc_q + step[AccW-1:0];
    assign acc_next = (state_q == StIdle) ? s1_sq_q : acc_ewma;
    assign mse_next = (|acc_next[AccW-1:WIDTH]) ? {WIDTH{1'b1}} : acc_next[WIDTH-1:0];
    assign cnt_next = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        if (clear) begin
            state_d = StIdle;
            hold_d  = '0;
        end else if (upd) begin
            if (state_q != StDiv && mse_next > div_thr) begin
                state_d = StDiv;
            end else begin
                case (state_q)
                    StIdle: state_d = StWarmup;
                    StWarmup: begin
                        if (cnt_next == CNT_W'(WARMUP)) begin
                            state_d = StTrack;
                        end
                    end
                    StTrack: begin
                        if (mse_next < conv_thr) begin
                            hold_d = hold_q + HoldW'(1);
                            if (hold_d == HoldW'(HOLD)) begin
                                state_d = StConv;
                            end
                        end else begin
                            hold_d = '0;
                        end
                    end
                    StConv: begin
                        if (mse_next >= conv_thr) begin
                            state_d = StTrack;
                            hold_d  = '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q       <= '0;
            mse_q       <= '0;
            mse_valid_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= StIdle;
            hold_q      <= '0;
        end else if (clear) begin
            acc_q       <= '0;
            mse_q       <= '0;
            mse_valid_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= StIdle;
            hold_q      <= '0;
        end else begin
            mse_valid_q <= upd;
            state_q     <= state_d;
            hold_q      <= hold_d;
            if (upd) begin
                acc_q <= acc_next;
                mse_q <= mse_next;
                cnt_q <= cnt_next;
            end
        end
    end

    assign mse_out    = mse_q;
    assign mse_valid  = mse_valid_q;
    assign sample_cnt = cnt_q;
    assign converged  = (state_q == StConv);
    assign diverged   = (state_q == StDiv);

`ifdef MSE_PEAK_EN
    logic [WIDTH-1:0] peak_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            peak_q <= '0;
        end else if (clear) begin
            peak_q <= '0;
        end else if (upd && mse_next > peak_q) begin
            peak_q <= mse_next;
        end
    end

    assign mse_peak = peak_q;
`else
    assign mse_peak = '0;
`endif

endmodule
